// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with registered operands and one registered result slot per requester.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_out,
  output logic             resp0_zero,
  output logic             resp0_slt,
  output logic             resp0_sltu,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_out,
  output logic             resp1_zero,
  output logic             resp1_slt,
  output logic             resp1_sltu,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_slt,
  input  logic             alu_sltu
);

  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             ctrl_q, ctrl_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic                   owner_q, owner_d;
  logic                   last_q, last_d;
  logic [1:0]             rvalid_q, rvalid_d;
  logic [1:0][WIDTH-1:0]  rout_q, rout_d;
  logic [1:0]             rzero_q, rzero_d;
  logic [1:0]             rslt_q, rslt_d;
  logic [1:0]             rsltu_q, rsltu_d;

  logic [1:0] elig;
  logic       gnt_any;
  logic       gnt_id;
  logic       is_sub;

  // Eligibility looks only at registered slot state, so a draining slot blocks its requester.
  assign elig    = {req1_valid & ~rvalid_q[1], req0_valid & ~rvalid_q[0]};
  assign gnt_any = (state_q == IDLE) && (elig != 2'b00);
  assign gnt_id  = (elig == 2'b11) ? ~last_q : elig[1];
  assign is_sub  = (ctrl_q == ALU_SUB);

  assign req0_ready = gnt_any & ~gnt_id;
  assign req1_ready = gnt_any & gnt_id;

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    a_d      = a_q;
    b_d      = b_q;
    owner_d  = owner_q;
    last_d   = last_q;
    rvalid_d = rvalid_q & ~{resp1_ready, resp0_ready};
    rout_d   = rout_q;
    rzero_d  = rzero_q;
    rslt_d   = rslt_q;
    rsltu_d  = rsltu_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          ctrl_d  = gnt_id ? req1_ctrl : req0_ctrl;
          a_d     = gnt_id ? req1_a    : req0_a;
          b_d     = gnt_id ? req1_b    : req0_b;
          owner_d = gnt_id;
          last_d  = gnt_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rvalid_d[owner_q] = 1'b1;
        rout_d[owner_q]   = alu_out;
        rzero_d[owner_q]  = is_sub & alu_zero;
        rslt_d[owner_q]   = is_sub & alu_slt;
        rsltu_d[owner_q]  = is_sub & alu_sltu;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      rvalid_q <= '0;
      rout_q   <= '0;
      rzero_q  <= '0;
      rslt_q   <= '0;
      rsltu_q  <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      a_q      <= a_d;
      b_q      <= b_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      rout_q   <= rout_d;
      rzero_q  <= rzero_d;
      rslt_q   <= rslt_d;
      rsltu_q  <= rsltu_d;
    end
  end

  assign alu_ctrl    = ctrl_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign resp0_valid = rvalid_q[0];
  assign resp0_out   = rout_q[0];
  assign resp0_zero  = rzero_q[0];
  assign resp0_slt   = rslt_q[0];
  assign resp0_sltu  = rsltu_q[0];
  assign resp1_valid = rvalid_q[1];
  assign resp1_out   = rout_q[1];
  assign resp1_zero  = rzero_q[1];
  assign resp1_slt   = rslt_q[1];
  assign resp1_sltu  = rsltu_q[1];

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters: req0 is the integer pipe, req1 is the address/branch unit.
- Each requester uses a valid/ready operation channel and a valid/ready response channel.
- Round-robin arbitration, registered operands and registered per-requester result slots.
- Sits between the issue logic and the single shared ALU instance; drives the ALU's Ctrl/A/B and samples its Out/zero/slt/sltu.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU datapath width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_ctrl  in  3  ALU op code, encoding from the shared macro header.
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B.
- resp0_valid  out  1  result slot 0 holds a result.
- resp0_ready  in  1  requester 0 consumes the result.
- resp0_out  out  WIDTH  result value.
- resp0_zero, resp0_slt, resp0_sltu  out  1 each  comparison flags.
- req1_*, resp1_*: same set as requester 0, for requester 1.
- alu_ctrl  out  3  to ALU Ctrl.
- alu_a  out  WIDTH  to ALU A.
- alu_b  out  WIDTH  to ALU B.
- alu_out  in  WIDTH  from ALU Out.
- alu_zero, alu_slt, alu_sltu  in  1 each  from ALU flags.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; operand regs (ctrl/a/b) = 0; owner=0; last_grant=1.
  - resp0_valid = resp1_valid = 0; all resp data/flag regs = 0.
  - Any in-flight operation is discarded; no response is produced for it.
- Eligibility: requester i is eligible when reqi_valid=1 and resp slot i is empty (respi_valid=0).
  - A slot being drained in the same cycle (respi_valid & respi_ready) does not count as empty; eligibility is evaluated on registered state only.
- Grant (combinational, IDLE only):
  - One requester eligible: grant it.
  - Both eligible: grant the requester that is not last_grant.
  - reqi_ready = (state==IDLE) & grant==i; at most one ready is high per cycle.
  - ready may depend on valid.
- FSM:
  - IDLE:
    - On grant: capture reqi_ctrl/a/b into the operand regs, owner=i, last_grant=i, go to EXEC.
    - Otherwise stay in IDLE.
  - EXEC (exactly one cycle):
    - alu_out is written into resp slot[owner] as sampled at the end of the cycle.
    - Flags are stored only when ctrl==SUB; for any other op they are stored as 0, never X.
    - Set respowner_valid=1; return to IDLE.
- ALU drive: alu_ctrl/alu_a/alu_b always reflect the operand regs (registered), including in IDLE; no combinational path from req inputs to the ALU.
- Latency: accept in cycle N (ready & valid), resp_valid=1 from cycle N+2. Throughput is one operation per 2 cycles.
- Response slot:
  - respi_valid holds, with data stable, until respi_ready=1.
  - It clears on the edge where respi_valid & respi_ready.
  - A slot cannot be refilled in the same cycle it drains.
- Requester holding: a requester may deassert valid before ready without side effects; no operation is latched without ready.
- Unknown/illegal ctrl code: forwarded unchanged; whatever alu_out returns is stored; flags stored as 0.
- Shift ops use only what the ALU computes from B; the arbiter does no masking.

Test Plan:
- Single op: after reset, req0 ADD a=5, b=7 -> req0_ready=1 in cycle N; resp0_valid=1 at N+2 with resp0_out=12 and flags 0.
- SUB flags: req1 SUB a=0x00000003, b=0xFFFFFFFF.
  - Expect resp1_out=0x00000004, zero=0, slt=0, sltu=1.
  - Then SUB a=9, b=9 -> out=0, zero=1, slt=0, sltu=0.
- Round-robin: both valid continuously with resp_ready=1 -> first grant goes to req0, then grants alternate 0,1,0,1. Check last_grant after reset favours req0.
- Backpressure: resp0_ready=0 with slot 0 full and req0 valid with a new op -> req0_ready stays 0; req1 ops are still served. Raise resp0_ready -> slot drains, and req0 is granted in the next IDLE cycle, not the drain cycle.
- Reset mid-op: assert rst_n=0 during EXEC of req1 XOR 0xF0F0, 0x0FF0 -> all outputs 0 immediately (async). After release, no resp1_valid appears.
- Operand isolation: change req0_a while req0_valid=1 and ready=0 -> alu_a is unchanged. Result matches the operands sampled on the accept edge.
